key_press_classifier: RTL and testbench
=======================================

Name: key_press_classifier

Overview:
Sits directly downstream of the key edge detector in the DDS signal generator front panel. It consumes the one-cycle edge_pos/edge_neg pulses of an active-low push-button (idle high) and debounces them in time. It classifies each press as short, long or long-with-auto-repeat, and emits single-cycle command pulses that the frequency/waveform control logic uses to step the DDS settings.

Parameters:
DEBOUNCE_CNT, 1_000_000, cycles an edge-free interval must last before a level is accepted (20 ms at 50 MHz); must be >= 2
LONG_CNT, 50_000_000, cycles of accepted hold before press_long fires (1 s); must be >= 2
REPEAT_CNT, 10_000_000, cycles between repeat_pulse outputs once long-held (200 ms); must be >= 2
CNT_W, 26, width of the internal counters; must satisfy 2^CNT_W > max(DEBOUNCE_CNT, LONG_CNT, REPEAT_CNT)

Ports:
clk  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
edge_pos  input  1  one-cycle pulse: key released (level rose)
edge_neg  input  1  one-cycle pulse: key pressed (level fell)
press_short  output  1  one-cycle pulse: press released before LONG_CNT
press_long  output  1  one-cycle pulse: hold reached LONG_CNT
repeat_pulse  output  1  one-cycle pulse every REPEAT_CNT cycles while long-held
key_held  output  1  level: 1 while in HELD, REPEAT or REL_DB

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters 0; key_lvl=1; long_fired=0; every output 0. Reset mid-press abandons the press and emits no pulse.
- key_lvl tracker: edge_neg sets it to 0; edge_pos sets it to 1; both in the same cycle leaves it unchanged. Any edge in a cycle is an "edge event".
- All outputs are registered. A pulse is high for exactly one cycle, in the cycle after the triggering condition.
- State IDLE: counters idle. edge_neg -> PRESS_DB with db_cnt=0. edge_pos is ignored.
- State PRESS_DB: an edge event clears db_cnt. Otherwise db_cnt increments.
  - When db_cnt==DEBOUNCE_CNT-1 with no edge event: key_lvl==0 -> HELD with hold_cnt=0 and long_fired=0; key_lvl==1 -> IDLE (glitch, no output).
- State HELD: hold_cnt increments each cycle.
  - edge_pos -> REL_DB with db_cnt=0; hold_cnt is frozen.
  - If hold_cnt==LONG_CNT-1 and no edge_pos: press_long pulses, long_fired=1, go to REPEAT with rep_cnt=0.
  - edge_pos in the same cycle as hold_cnt==LONG_CNT-1: release wins. No press_long; go to REL_DB.
- State REPEAT: rep_cnt increments.
  - At rep_cnt==REPEAT_CNT-1: repeat_pulse pulses and rep_cnt resets to 0.
  - edge_pos -> REL_DB and rep_cnt is frozen. Release coinciding with the repeat terminal count suppresses that repeat pulse.
- State REL_DB: an edge event clears db_cnt. Otherwise db_cnt increments.
  - When db_cnt==DEBOUNCE_CNT-1 with no edge event:
    - key_lvl==1 -> IDLE. press_short pulses if long_fired==0; no pulse if long_fired==1.
    - key_lvl==0 (bounce, key still down) -> resume HELD (long_fired==0) or REPEAT (long_fired==1), with frozen counters continuing.
- key_held is registered and decoded from the state.
- Press-to-output latency:
  - press_long appears DEBOUNCE_CNT + LONG_CNT + 1 cycles after the last press edge (allowing 1 cycle of registration slack).
  - press_short appears DEBOUNCE_CNT + 1 cycles after the last release edge.
- Counters never wrap: each is cleared at its terminal count or on a state change, as stated above.
- At most one of the three pulse outputs is high in any cycle.

Test Plan:
(All use DEBOUNCE_CNT=4, LONG_CNT=20, REPEAT_CNT=8.)
- Clean short press: edge_neg, 10 idle cycles, edge_pos, 10 idle cycles. Required: key_held high from PRESS_DB exit to IDLE entry; exactly one press_short, 5 cycles after edge_pos; no press_long.
- Bouncy press: edge_neg, edge_pos, edge_neg at 1-cycle spacing, then hold 30 cycles. Required: db_cnt restarts on each edge; press_long fires once, 4+20+1 cycles after the last edge_neg (±1 for registration).
- Long hold with repeat: press, hold 60 cycles past press_long, release. Required: press_long once, then repeat_pulse every 8 cycles (7 pulses), no press_short at release.
- Glitch press: edge_neg then edge_pos 2 cycles later, then idle 10. Required: return to IDLE, key_held never 1, no pulses.
- Release bounce while held: during HELD, edge_pos then edge_neg 2 cycles later. Required: return to HELD; hold_cnt resumes from its frozen value; press_long timing is delayed only by the REL_DB cycles.
- Reset mid-REPEAT: assert rst_n=0 for 3 cycles. Required: all outputs 0 immediately; no pulse after release; next press classifies normally.

Source files
------------

// File: rtl/key_press_classifier.sv
// Debounced push-button press classifier: short press, long press and
// auto-repeat pulses derived from key edge-detector pulses.
module key_press_classifier #(
  parameter int unsigned DEBOUNCE_CNT = 1_000_000,
  parameter int unsigned LONG_CNT     = 50_000_000,
  parameter int unsigned REPEAT_CNT   = 10_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic edge_pos,
  input  logic edge_neg,
  output logic press_short,
  output logic press_long,
  output logic repeat_pulse,
  output logic key_held
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PRS_DB = 3'd1;
  localparam logic [2:0] S_HELD   = 3'd2;
  localparam logic [2:0] S_REPEAT = 3'd3;
  localparam logic [2:0] S_REL_DB = 3'd4;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CNT - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CNT - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             key_lvl_q, key_lvl_d;
  logic             long_fired_q, long_fired_d;
  logic             press_short_q, press_short_d;
  logic             press_long_q, press_long_d;
  logic             repeat_pulse_q, repeat_pulse_d;
  logic             key_held_q, key_held_d;
  logic             edge_ev;

  assign edge_ev = edge_pos | edge_neg;

  always_comb begin
    key_lvl_d = key_lvl_q;
    if (edge_neg && !edge_pos) key_lvl_d = 1'b0;
    if (edge_pos && !edge_neg) key_lvl_d = 1'b1;
  end

  always_comb begin
    state_d        = state_q;
    db_cnt_d       = db_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    rep_cnt_d      = rep_cnt_q;
    long_fired_d   = long_fired_q;
    press_short_d  = 1'b0;
    press_long_d   = 1'b0;
    repeat_pulse_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (edge_neg) begin
          state_d  = S_PRS_DB;
          db_cnt_d = '0;
        end
      end
      S_PRS_DB: begin
        if (edge_ev) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          if (!key_lvl_q) begin
            state_d      = S_HELD;
            hold_cnt_d   = '0;
            long_fired_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          db_cnt_d = db_cnt_q + ONE;
        end
      end
      S_HELD: begin
        // release beats a coinciding long-press terminal count
        if (edge_pos) begin
          state_d  = S_REL_DB;
          db_cnt_d = '0;
        end else if (hold_cnt_q == LONG_LAST) begin
          state_d      = S_REPEAT;
          hold_cnt_d   = '0;
          rep_cnt_d    = '0;
          long_fired_d = 1'b1;
          press_long_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + ONE;
        end
      end
      S_REPEAT: begin
        if (edge_pos) begin
          state_d  = S_REL_DB;
          db_cnt_d = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d      = '0;
          repeat_pulse_d = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + ONE;
        end
      end
      S_REL_DB: begin
        if (edge_ev) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
          db_cnt_d = '0;
          if (key_lvl_q) begin
            state_d       = S_IDLE;
            press_short_d = !long_fired_q;
          end else begin
            // bounce: resume with the frozen hold/repeat count
            state_d = long_fired_q ? S_REPEAT : S_HELD;
          end
        end else begin
          db_cnt_d = db_cnt_q + ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    key_held_d = (state_d == S_HELD) || (state_d == S_REPEAT) ||
                 (state_d == S_REL_DB);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      db_cnt_q       <= '0;
      hold_cnt_q     <= '0;
      rep_cnt_q      <= '0;
      key_lvl_q      <= 1'b1;
      long_fired_q   <= 1'b0;
      press_short_q  <= 1'b0;
      press_long_q   <= 1'b0;
      repeat_pulse_q <= 1'b0;
      key_held_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      db_cnt_q       <= db_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      rep_cnt_q      <= rep_cnt_d;
      key_lvl_q      <= key_lvl_d;
      long_fired_q   <= long_fired_d;
      press_short_q  <= press_short_d;
      press_long_q   <= press_long_d;
      repeat_pulse_q <= repeat_pulse_d;
      key_held_q     <= key_held_d;
    end
  end

  assign press_short  = press_short_q;
  assign press_long   = press_long_q;
  assign repeat_pulse = repeat_pulse_q;
  assign key_held     = key_held_q;

endmodule

// File: tb/tb_key_press_classifier.sv
// Directed bench for key_press_classifier with small debounce/long/repeat
// counts; pulse timing is checked against hand-computed cycle numbers.
module tb_key_press_classifier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic edge_pos = 1'b0;
  logic edge_neg = 1'b0;
  logic press_short, press_long, repeat_pulse, key_held;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int n_short, n_long, n_rep, multi;
  int short_cyc, long_cyc, rep_first, rep_last;
  int held_seen, held_first, held_last, held_falls;
  logic prev_held = 1'b0;

  key_press_classifier #(
    .DEBOUNCE_CNT(4),
    .LONG_CNT(20),
    .REPEAT_CNT(8),
    .CNT_W(26)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .edge_pos(edge_pos),
    .edge_neg(edge_neg),
    .press_short(press_short),
    .press_long(press_long),
    .repeat_pulse(repeat_pulse),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (press_short) begin
      n_short++;
      short_cyc = cyc;
    end
    if (press_long) begin
      n_long++;
      long_cyc = cyc;
    end
    if (repeat_pulse) begin
      if (n_rep == 0) rep_first = cyc;
      n_rep++;
      rep_last = cyc;
    end
    if ((int'(press_short) + int'(press_long) + int'(repeat_pulse)) > 1)
      multi++;
    if (key_held) begin
      if (held_seen == 0) held_first = cyc;
      held_seen = 1;
      held_last = cyc;
    end
    if (prev_held && !key_held) held_falls++;
    prev_held = key_held;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic p, input logic n);
    @(negedge clk);
    edge_pos = p;
    edge_neg = n;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic clear_mon();
    @(posedge clk);
    #1;
    n_short = 0; n_long = 0; n_rep = 0; multi = 0;
    short_cyc = -1; long_cyc = -1; rep_first = -1; rep_last = -1;
    held_seen = 0; held_first = -1; held_last = -1; held_falls = 0;
  endtask

  int e, r, p;

  initial begin
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_short", press_short, 0);
    chk("rst_long", press_long, 0);
    chk("rst_rep", repeat_pulse, 0);
    chk("rst_held", key_held, 0);
    rst_n = 1'b1;
    idle(3);

    // clean short press
    clear_mon();
    step(1'b0, 1'b1); e = cyc;
    idle(10);
    step(1'b1, 1'b0); r = cyc;
    idle(10);
    chk("short_n", n_short, 1);
    chk("short_cyc", short_cyc, r + 5);
    chk("short_nolong", n_long, 0);
    chk("short_held_first", held_first, e + 5);
    chk("short_held_last", held_last, r + 4);
    chk("short_held_end", key_held, 0);

    // bouncy press then long hold
    clear_mon();
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1); e = cyc;
    idle(30);
    step(1'b1, 1'b0);
    idle(10);
    chk("bounce_long_n", n_long, 1);
    chk("bounce_long_cyc", long_cyc, e + 25);
    chk("bounce_noshort", n_short, 0);
    chk("bounce_norep", n_rep, 0);

    // long hold with auto-repeat
    clear_mon();
    step(1'b0, 1'b1); e = cyc;
    p = e + 25;
    idle(85);
    step(1'b1, 1'b0);
    idle(10);
    chk("rep_long_n", n_long, 1);
    chk("rep_long_cyc", long_cyc, p);
    chk("rep_n", n_rep, 7);
    chk("rep_first", rep_first, p + 8);
    chk("rep_last", rep_last, p + 56);
    chk("rep_noshort", n_short, 0);
    chk("rep_onehot", multi, 0);
    chk("rep_held_end", key_held, 0);

    // glitch press
    clear_mon();
    step(1'b0, 1'b1);
    idle(1);
    step(1'b1, 1'b0);
    idle(10);
    chk("glitch_held", held_seen, 0);
    chk("glitch_pulses", n_short + n_long + n_rep, 0);

    // release bounce while held
    clear_mon();
    step(1'b0, 1'b1); e = cyc;
    idle(9);
    step(1'b1, 1'b0);
    idle(1);
    step(1'b0, 1'b1);
    idle(21);
    chk("relb_falls", held_falls, 0);
    step(1'b1, 1'b0);
    idle(10);
    chk("relb_long_n", n_long, 1);
    chk("relb_long_cyc", long_cyc, e + 32);
    chk("relb_noshort", n_short, 0);

    // reset in the middle of auto-repeat
    clear_mon();
    step(1'b0, 1'b1);
    idle(30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_held", key_held, 0);
    chk("mrst_outs", press_short | press_long | repeat_pulse, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    step(1'b1, 1'b0);
    idle(10);
    chk("mrst_nopulse", n_short + n_long + n_rep, 0);
    chk("mrst_noheld", held_seen, 0);
    step(1'b0, 1'b1);
    idle(10);
    step(1'b1, 1'b0); r = cyc;
    idle(10);
    chk("mrst_short_n", n_short, 1);
    chk("mrst_short_cyc", short_cyc, r + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
